// File: rtl/iq_scheduler.sv
// 16-entry out-of-order issue queue: tag wakeup, dense relative ages, oldest-ready select.
// Select is a combinational min-age tree over registered entry state.
module iq_scheduler #(
   parameter int unsigned OPCODE_WIDTH  = 7,
   parameter int unsigned TAG_WIDTH     = 6,
   parameter int unsigned AGE_WIDTH     = 5,
   parameter int unsigned PAYLOAD_WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     disp_valid,
   output logic                     disp_ready,
   input  logic [OPCODE_WIDTH-1:0]  disp_op,
   input  logic [TAG_WIDTH-1:0]     disp_rs1_tag,
   input  logic [TAG_WIDTH-1:0]     disp_rs2_tag,
   input  logic                     disp_rs1_rdy,
   input  logic                     disp_rs2_rdy,
   input  logic [TAG_WIDTH-1:0]     disp_rd_tag,
   input  logic [PAYLOAD_WIDTH-1:0] disp_payload,
   input  logic                     wake_valid,
   input  logic [TAG_WIDTH-1:0]     wake_tag,
   output logic                     iss_valid,
   input  logic                     iss_ready,
   output logic [OPCODE_WIDTH-1:0]  iss_op,
   output logic [TAG_WIDTH-1:0]     iss_rd_tag,
   output logic [PAYLOAD_WIDTH-1:0] iss_payload,
   output logic [3:0]               iss_idx,
   output logic [4:0]               count
);

   localparam int unsigned ENTRIES = 16;
   localparam int unsigned IDX_W   = 4;
   localparam int unsigned CNT_W   = 5;

   typedef struct packed {
      logic [OPCODE_WIDTH-1:0]  op;
      logic [TAG_WIDTH-1:0]     rs1_tag;
      logic [TAG_WIDTH-1:0]     rs2_tag;
      logic [TAG_WIDTH-1:0]     rd_tag;
      logic [PAYLOAD_WIDTH-1:0] payload;
   } entry_t;

   typedef struct packed {
      logic                 v;
      logic [AGE_WIDTH-1:0] age;
      logic [IDX_W-1:0]     idx;
   } cand_t;

   logic [ENTRIES-1:0]   valid_q, valid_d;
   logic [ENTRIES-1:0]   rs1_rdy_q, rs1_rdy_d;
   logic [ENTRIES-1:0]   rs2_rdy_q, rs2_rdy_d;
   logic [AGE_WIDTH-1:0] age_q [ENTRIES];
   logic [AGE_WIDTH-1:0] age_d [ENTRIES];
   logic [CNT_W-1:0]     count_q, count_d;
   entry_t               ent_q [ENTRIES];

   logic             disp_fire;
   logic             iss_fire;
   logic [IDX_W-1:0] free_idx;

   cand_t lvl0 [16];
   cand_t lvl1 [8];
   cand_t lvl2 [4];
   cand_t lvl3 [2];
   cand_t root;

   // Left operand is always the lower index, so ties keep the lower index.
   function automatic cand_t pick(input cand_t a, input cand_t b);
      if (b.v && (!a.v || (b.age < a.age))) return b;
      return a;
   endfunction

   // Min-age selection tree over ready entries.
   always_comb begin
      for (int i = 0; i < 16; i++) begin
         lvl0[i].v   = valid_q[i] & rs1_rdy_q[i] & rs2_rdy_q[i];
         lvl0[i].age = age_q[i];
         lvl0[i].idx = IDX_W'(i);
      end
      for (int i = 0; i < 8; i++) lvl1[i] = pick(lvl0[2*i], lvl0[2*i+1]);
      for (int i = 0; i < 4; i++) lvl2[i] = pick(lvl1[2*i], lvl1[2*i+1]);
      for (int i = 0; i < 2; i++) lvl3[i] = pick(lvl2[2*i], lvl2[2*i+1]);
      root = pick(lvl3[0], lvl3[1]);
   end

   assign iss_valid   = root.v;
   assign iss_idx     = root.v ? root.idx : '0;
   assign iss_op      = root.v ? ent_q[root.idx].op      : '0;
   assign iss_rd_tag  = root.v ? ent_q[root.idx].rd_tag  : '0;
   assign iss_payload = root.v ? ent_q[root.idx].payload : '0;
   assign count       = count_q;
   assign disp_ready  = (count_q != CNT_W'(ENTRIES));
   assign disp_fire   = disp_valid & disp_ready;
   assign iss_fire    = root.v & iss_ready;

   // Lowest-index free slot.
   always_comb begin
      free_idx = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (!valid_q[i]) free_idx = IDX_W'(i);
      end
   end

   always_comb begin
      valid_d   = valid_q;
      rs1_rdy_d = rs1_rdy_q;
      rs2_rdy_d = rs2_rdy_q;
      age_d     = age_q;
      count_d   = count_q + CNT_W'(disp_fire) - CNT_W'(iss_fire);

      for (int i = 0; i < ENTRIES; i++) begin
         if (valid_q[i] && wake_valid) begin
            if (ent_q[i].rs1_tag == wake_tag) rs1_rdy_d[i] = 1'b1;
            if (ent_q[i].rs2_tag == wake_tag) rs2_rdy_d[i] = 1'b1;
         end
      end

      // Removing the selected entry closes its gap in the age order.
      if (iss_fire) begin
         valid_d[root.idx] = 1'b0;
         for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && (age_q[i] > root.age)) age_d[i] = age_q[i] - AGE_WIDTH'(1);
         end
      end

      if (disp_fire) begin
         valid_d[free_idx]   = 1'b1;
         age_d[free_idx]     = AGE_WIDTH'(count_q) - AGE_WIDTH'(iss_fire);
         rs1_rdy_d[free_idx] = disp_rs1_rdy | (wake_valid & (wake_tag == disp_rs1_tag));
         rs2_rdy_d[free_idx] = disp_rs2_rdy | (wake_valid & (wake_tag == disp_rs2_tag));
      end

      if (flush) begin
         valid_d = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q   <= '0;
         rs1_rdy_q <= '0;
         rs2_rdy_q <= '0;
         count_q   <= '0;
         for (int i = 0; i < ENTRIES; i++) age_q[i] <= '0;
      end else begin
         valid_q   <= valid_d;
         rs1_rdy_q <= rs1_rdy_d;
         rs2_rdy_q <= rs2_rdy_d;
         count_q   <= count_d;
         for (int i = 0; i < ENTRIES; i++) age_q[i] <= age_d[i];
      end
   end

   // Entry payload needs no reset; it is only observed behind a valid bit.
   always_ff @(posedge clk) begin
      if (disp_fire) begin
         ent_q[free_idx].op      <= disp_op;
         ent_q[free_idx].rs1_tag <= disp_rs1_tag;
         ent_q[free_idx].rs2_tag <= disp_rs2_tag;
         ent_q[free_idx].rd_tag  <= disp_rd_tag;
         ent_q[free_idx].payload <= disp_payload;
      end
   end

endmodule

// File: tb/tb_iq_scheduler.sv
// Directed bench for iq_scheduler: expected issues queued at dispatch, checked when they fire.
module tb_iq_scheduler;

   logic        clk = 1'b0;
   logic        rst, flush, disp_valid, disp_ready;
   logic [6:0]  disp_op;
   logic [5:0]  disp_rs1_tag, disp_rs2_tag, disp_rd_tag;
   logic        disp_rs1_rdy, disp_rs2_rdy;
   logic [63:0] disp_payload;
   logic        wake_valid;
   logic [5:0]  wake_tag;
   logic        iss_valid, iss_ready;
   logic [6:0]  iss_op;
   logic [5:0]  iss_rd_tag;
   logic [63:0] iss_payload;
   logic [3:0]  iss_idx;
   logic [4:0]  count;

   typedef struct {
      logic [3:0]  idx;
      logic [6:0]  op;
      logic [5:0]  rd;
      logic [63:0] payload;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   iq_scheduler dut (
      .clk(clk), .rst(rst), .flush(flush),
      .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
      .disp_rs1_tag(disp_rs1_tag), .disp_rs2_tag(disp_rs2_tag),
      .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy),
      .disp_rd_tag(disp_rd_tag), .disp_payload(disp_payload),
      .wake_valid(wake_valid), .wake_tag(wake_tag),
      .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
      .iss_rd_tag(iss_rd_tag), .iss_payload(iss_payload),
      .iss_idx(iss_idx), .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One dispatch cycle; optionally queue the expected issue record.
   task automatic disp(input logic [3:0] idx_exp, input logic [6:0] op, input logic [5:0] t1,
                       input logic r1, input logic [63:0] pl, input bit push);
      disp_valid   = 1'b1;
      disp_op      = op;
      disp_rs1_tag = t1;
      disp_rs1_rdy = r1;
      disp_rs2_tag = 6'd0;
      disp_rs2_rdy = 1'b1;
      disp_rd_tag  = pl[5:0];
      disp_payload = pl;
      if (push) sb.push_back('{idx_exp, op, pl[5:0], pl});
      tick();
      disp_valid = 1'b0;
   endtask

   task automatic wait_empty(input int maxc);
      int n;
      n = 0;
      while ((count != 5'd0 || sb.size() != 0) && n < maxc) begin
         tick();
         n++;
      end
      chk("drain_count", 64'(count), 64'd0);
      chk("drain_sb", 64'(sb.size()), 64'd0);
   endtask

   // Invariants plus scoreboard compare on every accepted issue.
   always @(negedge clk) begin : mon
      bit          ok;
      int          pc;
      bit [31:0]   seen;
      exp_t        e;
      if (!rst) begin
         ok = 1'b1;
         pc = 0;
         seen = '0;
         for (int i = 0; i < 16; i++) begin
            if (dut.valid_q[i]) begin
               pc++;
               if (dut.age_q[i] >= count || seen[dut.age_q[i]]) ok = 1'b0;
               seen[dut.age_q[i]] = 1'b1;
            end
         end
         if (pc != int'(count)) ok = 1'b0;
         chk("invariant", 64'(ok), 64'd1);
         if (iss_valid && iss_ready && !flush) begin
            chk("issue_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("iss_idx", 64'(iss_idx), 64'(e.idx));
               chk("iss_op", 64'(iss_op), 64'(e.op));
               chk("iss_rd_tag", 64'(iss_rd_tag), 64'(e.rd));
               chk("iss_payload", iss_payload, e.payload);
            end
         end
      end
   end

   initial begin
      rst = 1'b1; flush = 1'b0; disp_valid = 1'b0; disp_op = '0;
      disp_rs1_tag = '0; disp_rs2_tag = '0; disp_rs1_rdy = 1'b0; disp_rs2_rdy = 1'b0;
      disp_rd_tag = '0; disp_payload = '0; wake_valid = 1'b0; wake_tag = '0; iss_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_disp_ready", 64'(disp_ready), 64'd1);
      chk("rst_iss_valid", 64'(iss_valid), 64'd0);
      chk("rst_iss_idx", 64'(iss_idx), 64'd0);
      chk("rst_iss_op", 64'(iss_op), 64'd0);
      chk("rst_iss_rd", 64'(iss_rd_tag), 64'd0);
      chk("rst_iss_payload", iss_payload, 64'd0);

      // Back-to-back ready ops; the slot freed by the first issue is reused by the third.
      iss_ready = 1'b1;
      disp(4'd0, 7'h11, 6'd1, 1'b1, 64'hA000_0000_0000_0001, 1'b1);
      disp(4'd1, 7'h12, 6'd1, 1'b1, 64'hA000_0000_0000_0002, 1'b1);
      disp(4'd0, 7'h13, 6'd1, 1'b1, 64'hA000_0000_0000_0003, 1'b1);
      wait_empty(10);

      // Younger ready op bypasses an older waiting one; wakeup releases the older.
      disp(4'd0, 7'h21, 6'd5, 1'b0, 64'hB000_0000_0000_000A, 1'b0);
      disp(4'd1, 7'h22, 6'd1, 1'b1, 64'hB000_0000_0000_000B, 1'b1);
      sb.push_back('{4'd0, 7'h21, 6'h0A, 64'hB000_0000_0000_000A});
      tick();
      chk("t2_blocked", 64'(iss_valid), 64'd0);
      wake_valid = 1'b1; wake_tag = 6'd5;
      tick();
      wake_valid = 1'b0;
      chk("t2_woken_valid", 64'(iss_valid), 64'd1);
      chk("t2_woken_idx", 64'(iss_idx), 64'd0);
      wait_empty(10);

      // Fill, reject when full, then wake all and drain in dispatch order.
      iss_ready = 1'b0;
      for (int i = 0; i < 16; i++)
         disp(4'(i), 7'(8'h30 + i), 6'(20 + i), 1'b0, 64'hC000_0000_0000_0000 + 64'(i), 1'b1);
      chk("t3_full_count", 64'(count), 64'd16);
      chk("t3_full_ready", 64'(disp_ready), 64'd0);
      disp(4'd0, 7'h7F, 6'd1, 1'b1, 64'hDEAD_DEAD_DEAD_DEAD, 1'b0);
      chk("t3_reject_count", 64'(count), 64'd16);
      for (int i = 0; i < 16; i++) begin
         wake_valid = 1'b1; wake_tag = 6'(20 + i);
         tick();
      end
      wake_valid = 1'b0;
      chk("t3_woken_idx", 64'(iss_idx), 64'd0);
      iss_ready = 1'b1;
      wait_empty(40);

      // Stall holds the oldest; then issue and dispatch in the same cycle.
      iss_ready = 1'b0;
      disp(4'd0, 7'h41, 6'd1, 1'b1, 64'hD000_0000_0000_0001, 1'b1);
      disp(4'd1, 7'h42, 6'd1, 1'b1, 64'hD000_0000_0000_0002, 1'b1);
      disp(4'd2, 7'h43, 6'd1, 1'b1, 64'hD000_0000_0000_0003, 1'b1);
      for (int i = 0; i < 3; i++) begin
         chk("t4_hold_valid", 64'(iss_valid), 64'd1);
         chk("t4_hold_idx", 64'(iss_idx), 64'd0);
         tick();
      end
      iss_ready = 1'b1;
      disp(4'd3, 7'h44, 6'd1, 1'b1, 64'hD000_0000_0000_0004, 1'b1);
      iss_ready = 1'b0;
      chk("t4_count", 64'(count), 64'd3);
      chk("t4_age1", 64'(dut.age_q[1]), 64'd0);
      chk("t4_age2", 64'(dut.age_q[2]), 64'd1);
      chk("t4_age3", 64'(dut.age_q[3]), 64'd2);
      iss_ready = 1'b1;
      wait_empty(10);

      // Same-cycle wakeup bypass at dispatch.
      wake_valid = 1'b1; wake_tag = 6'd9;
      disp(4'd0, 7'h51, 6'd9, 1'b0, 64'hE000_0000_0000_0009, 1'b1);
      wake_valid = 1'b0;
      chk("t5_bypass_valid", 64'(iss_valid), 64'd1);
      chk("t5_bypass_idx", 64'(iss_idx), 64'd0);
      wait_empty(10);

      // Flush beats a simultaneous dispatch.
      iss_ready = 1'b0;
      for (int i = 0; i < 10; i++)
         disp(4'(i), 7'h60, 6'd1, 1'b1, 64'hF000_0000_0000_0000 + 64'(i), 1'b0);
      chk("t6_count10", 64'(count), 64'd10);
      flush = 1'b1;
      disp(4'd0, 7'h6F, 6'd1, 1'b1, 64'hF0F0_F0F0_F0F0_F0F0, 1'b0);
      flush = 1'b0;
      chk("t6_flush_count", 64'(count), 64'd0);
      chk("t6_flush_iss_valid", 64'(iss_valid), 64'd0);
      iss_ready = 1'b1;
      tick();
      tick();
      chk("t6_post_iss_valid", 64'(iss_valid), 64'd0);

      // Reset mid-operation.
      iss_ready = 1'b0;
      disp(4'd0, 7'h71, 6'd1, 1'b1, 64'h7100, 1'b0);
      disp(4'd1, 7'h72, 6'd1, 1'b1, 64'h7200, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t7_count", 64'(count), 64'd0);
      chk("t7_disp_ready", 64'(disp_ready), 64'd1);
      chk("t7_iss_valid", 64'(iss_valid), 64'd0);
      chk("t7_iss_idx", 64'(iss_idx), 64'd0);
      chk("t7_iss_payload", iss_payload, 64'd0);
      tick();
      chk("final_sb_empty", 64'(sb.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
